// File: rtl/instruction_queue_pkg.sv
// Shared types and sizing for the instruction queue.
// Holds the decoded instruction-type encoding, the fully resolved queue entry
// layout, and the default depth / pop width used by the queue and its interface.
package instruction_queue_pkg;

  localparam int IQ_LOG_DEPTH = 4;
  localparam int IQ_POP_WIDTH = 3;
  localparam int IQ_ADDR_W    = 18;

  typedef enum logic [1:0] {
    INSTR_TYPE_NONE  = 2'd0,
    INSTR_TYPE_ARITH = 2'd1,
    INSTR_TYPE_LD_ST = 2'd2,
    INSTR_TYPE_RAM   = 2'd3
  } instr_type_e;

  // One resolved instruction: type, per-unit fields, and the four APU addresses.
  typedef struct packed {
    instr_type_e          instr_type;
    logic [13:0]          arith;
    logic [8:0]           ram;
    logic [9:0]           ld_st;
    logic [IQ_ADDR_W-1:0] cache_addr;
    logic [IQ_ADDR_W-1:0] main_mem_addr;
    logic [IQ_ADDR_W-1:0] d_cache_addr;
    logic [IQ_ADDR_W-1:0] d_main_mem_addr;
  } iq_entry_t;

endpackage

// File: rtl/instruction_queue_if.sv
// Push/pop bundle of the instruction queue.
// master : control_unit + issue side (drives push_we/push_entry/pop_cnt).
// slave  : the queue itself (drives full/almost_full/pop window/count/errors).
interface instruction_queue_if
  import instruction_queue_pkg::*;
#(
  parameter int LOG_DEPTH = IQ_LOG_DEPTH,
  parameter int POP_WIDTH = IQ_POP_WIDTH
) ();

  logic                             push_we;
  iq_entry_t                        push_entry;
  logic                             full;
  logic                             almost_full;
  logic [1:0]                       pop_cnt;
  logic [POP_WIDTH-1:0]             pop_valid;
  iq_entry_t [POP_WIDTH-1:0]        pop_entry;
  logic [LOG_DEPTH:0]               count;
  logic                             overflow_err;
  logic                             underflow_err;

  modport master (
    output push_we, push_entry, pop_cnt,
    input  full, almost_full, pop_valid, pop_entry, count,
           overflow_err, underflow_err
  );

  modport slave (
    input  push_we, push_entry, pop_cnt,
    output full, almost_full, pop_valid, pop_entry, count,
           overflow_err, underflow_err
  );

endinterface

// File: rtl/instruction_queue_pop_window.sv
// Rotating read mux: presents POP_WIDTH consecutive entries starting at head.
// Ports:
//   mem_i   in  storage array (DEPTH entries)
//   head_i  in  read pointer
//   slot_o  out slot i = mem_i[(head_i + i) mod DEPTH]
module instruction_queue_pop_window
  import instruction_queue_pkg::*;
#(
  parameter int LOG_DEPTH = IQ_LOG_DEPTH,
  parameter int POP_WIDTH = IQ_POP_WIDTH
) (
  input  iq_entry_t                 mem_i [2**LOG_DEPTH],
  input  logic [LOG_DEPTH-1:0]      head_i,
  output iq_entry_t [POP_WIDTH-1:0] slot_o
);

  for (genvar i = 0; i < POP_WIDTH; i++) begin : g_slot
    // LOG_DEPTH-bit sum wraps modulo DEPTH on its own.
    logic [LOG_DEPTH-1:0] idx;
    assign idx       = head_i + LOG_DEPTH'(i);
    assign slot_o[i] = mem_i[idx];
  end

endmodule

// File: rtl/instruction_queue.sv
// Instruction queue: FWFT decoupling FIFO between control_unit (<=1 push per
// cycle) and the issue stage (<=POP_WIDTH pops per cycle).
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high; empties the queue and clears errors
//   q      instruction_queue_if.slave: push_we/push_entry, full, almost_full,
//          pop_cnt, pop_valid, pop_entry, count, overflow_err, underflow_err
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int LOG_DEPTH = IQ_LOG_DEPTH,
  parameter int POP_WIDTH = IQ_POP_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  instruction_queue_if.slave  q
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  typedef logic [LOG_DEPTH:0]   cnt_t;
  typedef logic [LOG_DEPTH-1:0] ptr_t;

  // Entries actually consumed: request clamped to POP_WIDTH, then to occupancy.
  function automatic cnt_t eff_pop_f(input logic [1:0] req, input cnt_t cnt);
    cnt_t r;
    r = cnt_t'(req);
    if (r > cnt_t'(POP_WIDTH)) r = cnt_t'(POP_WIDTH);
    if (r > cnt) r = cnt;
    return r;
  endfunction

  iq_entry_t mem_q [DEPTH];
  ptr_t      head_q, head_d;
  ptr_t      tail_q, tail_d;
  cnt_t      count_q, count_d;
  logic      ovf_q, ovf_d;
  logic      unf_q, unf_d;

  logic      full;
  logic      push_acc;
  cnt_t      eff_pop;

  // full is taken from the pre-pop count: no push-through on a full queue.
  assign full     = (count_q == cnt_t'(DEPTH));
  assign push_acc = q.push_we && !full;
  assign eff_pop  = eff_pop_f(q.pop_cnt, count_q);

  always_comb begin
    head_d  = head_q + eff_pop[LOG_DEPTH-1:0];
    tail_d  = tail_q + ptr_t'(push_acc);
    count_d = count_q + cnt_t'(push_acc) - eff_pop;
    ovf_d   = ovf_q | (q.push_we & full);
    unf_d   = unf_q | (cnt_t'(q.pop_cnt) > count_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never cleared; reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[tail_q] <= q.push_entry;
  end

  instruction_queue_pop_window #(
    .LOG_DEPTH (LOG_DEPTH),
    .POP_WIDTH (POP_WIDTH)
  ) u_pop_window (
    .mem_i  (mem_q),
    .head_i (head_q),
    .slot_o (q.pop_entry)
  );

  for (genvar i = 0; i < POP_WIDTH; i++) begin : g_valid
    assign q.pop_valid[i] = (count_q > cnt_t'(i));
  end

  assign q.full          = full;
  assign q.almost_full   = (count_q >= cnt_t'(DEPTH - 2));
  assign q.count         = count_q;
  assign q.overflow_err  = ovf_q;
  assign q.underflow_err = unf_q;

endmodule
